// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register file write-back arbiter: ALU priority, in-order load FIFO
// Optional WB_BYPASS_EN: a load arriving to an empty FIFO with no ALU write goes straight to the output.
module regfile_writeback #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid,
  input  logic [ADDR_W-1:0]             alu_rd,
  input  logic [DATA_W-1:0]             alu_data,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [ADDR_W-1:0]             mem_rd,
  input  logic [DATA_W-1:0]             mem_data,
  output logic                          reg_write_en,
  output logic [ADDR_W-1:0]             reg_write_dest,
  output logic [DATA_W-1:0]             reg_write_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          idle
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fifo_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic fifo_empty;
  logic alu_take;
  logic mem_fire;
  logic mem_keep;
  logic pop;
  logic push;
  logic bypass;

  assign fifo_empty = (count == '0);
  // Ready looks only at the registered count, so a full FIFO refuses even when popping.
  assign mem_ready  = (count < CNT_W'(FIFO_DEPTH));
  assign fifo_count = count;
  assign idle       = fifo_empty && !reg_write_en;

  assign alu_take = alu_valid && (alu_rd != '0);
  assign mem_fire = mem_valid && mem_ready;
  assign mem_keep = mem_fire && (mem_rd != '0);
  assign pop      = !alu_take && !fifo_empty;

`ifdef WB_BYPASS_EN
  assign bypass = mem_keep && fifo_empty && !alu_take;
`else
  assign bypass = 1'b0;
`endif

  assign push = mem_keep && !bypass;

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= mem_rd;
      fifo_data[wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_en   <= 1'b0;
      reg_write_dest <= '0;
      reg_write_data <= '0;
    end else if (alu_take) begin
      reg_write_en   <= 1'b1;
      reg_write_dest <= alu_rd;
      reg_write_data <= alu_data;
    end else if (pop) begin
      reg_write_en   <= 1'b1;
      reg_write_dest <= fifo_rd[rd_ptr];
      reg_write_data <= fifo_data[rd_ptr];
    end else if (bypass) begin
      reg_write_en   <= 1'b1;
      reg_write_dest <= mem_rd;
      reg_write_data <= mem_data;
    end else begin
      reg_write_en   <= 1'b0;
    end
  end

endmodule
